// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Scoreboard-based hazard unit beside the decode stage. Every issued register
//   write is tracked through NB_STAGES post-decode stages (entry 0 = EX,
//   entry NB_STAGES-1 = register write). Decode is stalled on unresolved RAW
//   hazards. With FORWARDING=1, bypass selects are produced and only load-use
//   stalls. A taken branch discards the next FLUSH_DEPTH instructions entering
//   EX. A saturating counter records stall cycles.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-low reset
//   dec_valid_i                  decode holds a valid instruction
//   dec_raddr1_i/dec_raddr2_i    source registers
//   dec_rs1_used_i/dec_rs2_used_i  operand actually read
//   dec_reg_write_i/dec_reg_addr_i/dec_is_load_i  destination info
//   branch_i                     taken branch resolved in EX
//   perf_clear_i                 clear the stall counter
//   ex_discard_o                 discard instruction entering EX (from flush register)
//   dec_stall_request_o          hold decode (combinational)
//   fwd_sel1_o/fwd_sel2_o        0 = register file, k+1 = result of entry k
//   stall_count_o                stall cycles since reset/clear, saturating
module hazard_scoreboard #(
    parameter int NB_STAGES   = 3,
    parameter int FORWARDING  = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           dec_valid_i,
    input  logic [4:0]                     dec_raddr1_i,
    input  logic [4:0]                     dec_raddr2_i,
    input  logic                           dec_rs1_used_i,
    input  logic                           dec_rs2_used_i,
    input  logic                           dec_reg_write_i,
    input  logic [4:0]                     dec_reg_addr_i,
    input  logic                           dec_is_load_i,
    input  logic                           branch_i,
    input  logic                           perf_clear_i,
    output logic                           ex_discard_o,
    output logic                           dec_stall_request_o,
    output logic [$clog2(NB_STAGES+1)-1:0] fwd_sel1_o,
    output logic [$clog2(NB_STAGES+1)-1:0] fwd_sel2_o,
    output logic [CNT_WIDTH-1:0]           stall_count_o
);

    localparam int SEL_W = $clog2(NB_STAGES+1);
    localparam int FL_W  = $clog2(FLUSH_DEPTH+1);

    typedef struct packed {
        logic       valid;
        logic [4:0] addr;
        logic       is_load;
    } sb_entry_t;

    sb_entry_t [NB_STAGES-1:0] sb_q;
    sb_entry_t                 new_entry;
    logic [FL_W-1:0]           flush_q;
    logic [CNT_WIDTH-1:0]      cnt_q;

    logic             hit1, hit2;
    logic [SEL_W-1:0] idx1, idx2;
    logic             load_use;
    logic             raw_stall;
    logic             stall;

    // Scan oldest to youngest so the youngest (lowest k) match overwrites.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        idx1 = '0;
        idx2 = '0;
        for (int k = NB_STAGES-1; k >= 0; k--) begin
            if (dec_rs1_used_i && dec_raddr1_i != 5'd0 && sb_q[k].valid &&
                sb_q[k].addr == dec_raddr1_i) begin
                hit1 = 1'b1;
                idx1 = SEL_W'(k);
            end
            if (dec_rs2_used_i && dec_raddr2_i != 5'd0 && sb_q[k].valid &&
                sb_q[k].addr == dec_raddr2_i) begin
                hit2 = 1'b1;
                idx2 = SEL_W'(k);
            end
        end
    end

    // A load in EX has no result yet: the only case forwarding cannot cover.
    assign load_use  = sb_q[0].is_load &&
                       ((hit1 && idx1 == '0) || (hit2 && idx2 == '0));
    assign raw_stall = (FORWARDING != 0) ? load_use : (hit1 || hit2);
    assign stall     = dec_valid_i && !ex_discard_o && !branch_i && raw_stall;

    assign dec_stall_request_o = stall;
    assign fwd_sel1_o = (FORWARDING != 0 && hit1 && !stall) ? idx1 + SEL_W'(1) : '0;
    assign fwd_sel2_o = (FORWARDING != 0 && hit2 && !stall) ? idx2 + SEL_W'(1) : '0;

    assign ex_discard_o  = (flush_q != '0);
    assign stall_count_o = cnt_q;

    // Anything not actually advancing into EX enters as a bubble.
    always_comb begin
        new_entry = '0;
        if (dec_valid_i && dec_reg_write_i && dec_reg_addr_i != 5'd0 &&
            !stall && !ex_discard_o && !branch_i) begin
            new_entry.valid   = 1'b1;
            new_entry.addr    = dec_reg_addr_i;
            new_entry.is_load = dec_is_load_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sb_q    <= '0;
            flush_q <= '0;
            cnt_q   <= '0;
        end else begin
            sb_q <= {sb_q[NB_STAGES-2:0], new_entry};

            // A branch during a flush restarts it rather than extending it.
            if (branch_i)
                flush_q <= FL_W'(FLUSH_DEPTH);
            else if (flush_q != '0)
                flush_q <= flush_q - FL_W'(1);

            if (perf_clear_i)
                cnt_q <= '0;
            else if (stall && !(&cnt_q))
                cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Two instances share all inputs:
// u_fwd (FORWARDING=1, CNT_WIDTH=4) and u_nofwd (FORWARDING=0, CNT_WIDTH=16),
// both NB_STAGES=3, FLUSH_DEPTH=2. Inputs change 1ns after the rising edge;
// outputs are checked on the falling edge.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid;
    logic [4:0] raddr1, raddr2;
    logic       rs1_used, rs2_used;
    logic       reg_write;
    logic [4:0] reg_addr;
    logic       is_load;
    logic       branch;
    logic       perf_clear;

    logic        f_discard, f_stall;
    logic [1:0]  f_sel1, f_sel2;
    logic [3:0]  f_cnt;
    logic        n_discard, n_stall;
    logic [1:0]  n_sel1, n_sel2;
    logic [15:0] n_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NB_STAGES(3), .FORWARDING(1), .FLUSH_DEPTH(2), .CNT_WIDTH(4)) u_fwd (
        .clk_i(clk), .rst_i(rst), .dec_valid_i(dec_valid),
        .dec_raddr1_i(raddr1), .dec_raddr2_i(raddr2),
        .dec_rs1_used_i(rs1_used), .dec_rs2_used_i(rs2_used),
        .dec_reg_write_i(reg_write), .dec_reg_addr_i(reg_addr), .dec_is_load_i(is_load),
        .branch_i(branch), .perf_clear_i(perf_clear),
        .ex_discard_o(f_discard), .dec_stall_request_o(f_stall),
        .fwd_sel1_o(f_sel1), .fwd_sel2_o(f_sel2), .stall_count_o(f_cnt)
    );

    hazard_scoreboard #(.NB_STAGES(3), .FORWARDING(0), .FLUSH_DEPTH(2), .CNT_WIDTH(16)) u_nofwd (
        .clk_i(clk), .rst_i(rst), .dec_valid_i(dec_valid),
        .dec_raddr1_i(raddr1), .dec_raddr2_i(raddr2),
        .dec_rs1_used_i(rs1_used), .dec_rs2_used_i(rs2_used),
        .dec_reg_write_i(reg_write), .dec_reg_addr_i(reg_addr), .dec_is_load_i(is_load),
        .branch_i(branch), .perf_clear_i(perf_clear),
        .ex_discard_o(n_discard), .dec_stall_request_o(n_stall),
        .fwd_sel1_o(n_sel1), .fwd_sel2_o(n_sel2), .stall_count_o(n_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clr_in();
        dec_valid  = 1'b0;
        raddr1     = 5'd0;
        raddr2     = 5'd0;
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        reg_write  = 1'b0;
        reg_addr   = 5'd0;
        is_load    = 1'b0;
        branch     = 1'b0;
        perf_clear = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic ld);
        clr_in();
        dec_valid = 1'b1;
        reg_write = 1'b1;
        reg_addr  = a;
        is_load   = ld;
    endtask

    task automatic rd(input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2);
        clr_in();
        dec_valid = 1'b1;
        raddr1    = a1;
        rs1_used  = u1;
        raddr2    = a2;
        rs2_used  = u2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        rst = 1'b0;
        #1;

        // ---- reset with random inputs ----
        repeat (2) begin
            dec_valid  = 1'($urandom);
            raddr1     = 5'($urandom);
            raddr2     = 5'($urandom);
            rs1_used   = 1'($urandom);
            rs2_used   = 1'($urandom);
            reg_write  = 1'($urandom);
            reg_addr   = 5'($urandom);
            is_load    = 1'($urandom);
            branch     = 1'($urandom);
            perf_clear = 1'($urandom);
            edge_();
        end
        rst = 1'b1;
        rd(5'($urandom), 1'b1, 5'($urandom), 1'b1);
        settle();
        chk("rst_f_discard", 32'(f_discard), 0);
        chk("rst_n_discard", 32'(n_discard), 0);
        chk("rst_f_cnt",     32'(f_cnt), 0);
        chk("rst_n_cnt",     32'(n_cnt), 0);
        chk("rst_f_stall",   32'(f_stall), 0);
        chk("rst_n_stall",   32'(n_stall), 0);
        chk("rst_f_sel1",    32'(f_sel1), 0);
        chk("rst_f_sel2",    32'(f_sel2), 0);
        edge_();

        // ---- ALU write x5 then dependent read: bypass walk / no-fwd stall ----
        wr(5'd5, 1'b0);
        edge_();
        rd(5'd5, 1'b1, 5'd0, 1'b0);
        settle();
        chk("alu_f_stall_k0", 32'(f_stall), 0);
        chk("alu_f_sel1_k0",  32'(f_sel1), 1);
        chk("alu_f_sel2_k0",  32'(f_sel2), 0);
        chk("alu_n_stall_k0", 32'(n_stall), 1);
        chk("alu_n_sel1_k0",  32'(n_sel1), 0);
        edge_();
        settle();
        chk("alu_f_sel1_k1",  32'(f_sel1), 2);
        chk("alu_n_stall_k1", 32'(n_stall), 1);
        edge_();
        settle();
        chk("alu_f_sel1_k2",  32'(f_sel1), 3);
        chk("alu_n_stall_k2", 32'(n_stall), 1);
        edge_();
        settle();
        chk("alu_f_sel1_ret",  32'(f_sel1), 0);
        chk("alu_n_stall_ret", 32'(n_stall), 0);
        chk("alu_n_sel1_ret",  32'(n_sel1), 0);
        chk("alu_n_cnt",       32'(n_cnt), 3);
        chk("alu_f_cnt",       32'(f_cnt), 0);
        edge_();

        // ---- youngest match wins ----
        wr(5'd9, 1'b0);
        edge_();
        wr(5'd9, 1'b0);
        edge_();
        rd(5'd9, 1'b1, 5'd9, 1'b1);
        settle();
        chk("young_f_sel1", 32'(f_sel1), 1);
        chk("young_f_sel2", 32'(f_sel2), 1);
        edge_();
        clr_in();
        repeat (3) edge_();

        // ---- x0 never tracked, unused operand never matches ----
        wr(5'd0, 1'b0);
        edge_();
        wr(5'd6, 1'b0);
        edge_();
        rd(5'd0, 1'b1, 5'd6, 1'b0);
        settle();
        chk("x0_n_stall", 32'(n_stall), 0);
        chk("x0_f_sel1",  32'(f_sel1), 0);
        chk("x0_f_sel2",  32'(f_sel2), 0);
        edge_();

        // ---- load-use via rs2 ----
        clr_in();
        perf_clear = 1'b1;
        edge_();
        wr(5'd7, 1'b1);
        edge_();
        rd(5'd0, 1'b0, 5'd7, 1'b1);
        settle();
        chk("lu_f_stall", 32'(f_stall), 1);
        chk("lu_f_sel2",  32'(f_sel2), 0);
        edge_();
        settle();
        chk("lu_f_stall_rel", 32'(f_stall), 0);
        chk("lu_f_sel2_rel",  32'(f_sel2), 2);
        chk("lu_f_cnt",       32'(f_cnt), 1);
        edge_();
        clr_in();
        repeat (3) edge_();

        // ---- back-to-back branch: flush reload, stall mask, no insertion ----
        wr(5'd4, 1'b0);
        edge_();
        wr(5'd4, 1'b0);
        rs1_used = 1'b1;
        raddr1   = 5'd4;
        branch   = 1'b1;
        settle();
        chk("br_t_discard",  32'(f_discard), 0);
        chk("br_t_n_stall",  32'(n_stall), 0);
        edge_();
        settle();
        chk("br_t1_discard", 32'(f_discard), 1);
        chk("br_t1_n_stall", 32'(n_stall), 0);
        edge_();
        branch = 1'b0;
        settle();
        chk("br_t2_discard", 32'(n_discard), 1);
        chk("br_t2_n_stall", 32'(n_stall), 0);
        edge_();
        settle();
        chk("br_t3_discard", 32'(f_discard), 1);
        edge_();
        rd(5'd4, 1'b1, 5'd0, 1'b0);
        settle();
        chk("br_t4_discard", 32'(f_discard), 0);
        chk("br_t4_n_stall", 32'(n_stall), 0);
        chk("br_t4_f_sel1",  32'(f_sel1), 0);
        edge_();

        // ---- reset in the middle of a flush ----
        clr_in();
        branch = 1'b1;
        edge_();
        branch = 1'b0;
        rst    = 1'b0;
        settle();
        chk("rstfl_pre", 32'(f_discard), 1);
        edge_();
        rst = 1'b1;
        settle();
        chk("rstfl_post", 32'(f_discard), 0);
        edge_();

        // ---- counter saturation (CNT_WIDTH=4): load reading its own dest ----
        // Alternates insert / load-use stall, so stalls land on even cycles.
        rst = 1'b0;
        edge_();
        rst = 1'b1;
        wr(5'd7, 1'b1);
        raddr1   = 5'd7;
        rs1_used = 1'b1;
        repeat (28) edge_();
        settle();
        chk("sat_cnt14", 32'(f_cnt), 14);
        repeat (12) edge_();
        settle();
        chk("sat_cnt15",  32'(f_cnt), 15);
        chk("sat_stall0", 32'(f_stall), 0);
        chk("sat_sel1",   32'(f_sel1), 2);
        edge_();
        perf_clear = 1'b1;
        settle();
        chk("clr_stall", 32'(f_stall), 1);
        edge_();
        clr_in();
        settle();
        chk("clr_cnt", 32'(f_cnt), 0);
        edge_();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the ECAP5-DPROC pipeline, replacing per-stage address comparison with an internal scoreboard of in-flight register writes. It sits beside the decode stage: it tracks every issued destination register through NB_STAGES post-decode stages and raises a decode stall on unresolved RAW hazards. With forwarding enabled it emits bypass selects for both source operands, stalling only on load-use. It also sequences a multi-cycle branch flush and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- NB_STAGES, 3, post-decode stages tracked (entry 0 = EX, entry NB_STAGES-1 = register write stage); legal 2..8
- FORWARDING, 1, 0 = stall on any RAW match, 1 = bypass with load-use stall only
- FLUSH_DEPTH, 2, cycles ex_discard_o is held after a taken branch; legal 1..4
- CNT_WIDTH, 16, stall counter width

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-low
- dec_valid_i  in  1  decode holds a valid instruction
- dec_raddr1_i / dec_raddr2_i  in  5  source register addresses
- dec_rs1_used_i / dec_rs2_used_i  in  1  operand actually read
- dec_reg_write_i  in  1  instruction writes a register
- dec_reg_addr_i  in  5  destination register
- dec_is_load_i  in  1  instruction is a load
- branch_i  in  1  taken branch resolved in EX this cycle
- perf_clear_i  in  1  clear stall counter
- ex_discard_o  out  1  registered; discard instruction entering EX
- dec_stall_request_o  out  1  combinational; hold decode
- fwd_sel1_o / fwd_sel2_o  out  $clog2(NB_STAGES+1)  0 = register file, k+1 = result of entry k
- stall_count_o  out  CNT_WIDTH  stall cycles since reset/clear

## Operation
- Scoreboard: NB_STAGES entries {valid, addr, is_load}. Every cycle entry k moves to k+1; entry NB_STAGES-1 retires. Stages after decode never stall.
- Entry 0 load: {1, dec_reg_addr_i, dec_is_load_i} when dec_valid_i & dec_reg_write_i & dec_reg_addr_i!=0 & !dec_stall_request_o & !ex_discard_o & !branch_i; otherwise a bubble (valid=0).
- Match for operand n: rsn_used & raddrn!=0 & valid entry with same addr; youngest (lowest k) match wins.
- FORWARDING=0: stall if either operand matches any entry; fwd_sel = 0.
- FORWARDING=1: stall if the winning match is entry 0 with is_load=1; otherwise fwd_sel = k+1 of winning match, 0 if none. fwd_sel forced to 0 while stalled.
- Stall masked (0) when dec_valid_i=0, ex_discard_o=1 or branch_i=1.
- Flush: branch_i loads the flush counter with FLUSH_DEPTH; ex_discard_o = (counter!=0), counter decrements each cycle. branch_i during an active flush reloads it (no accumulation).
- Counter: increments on each cycle dec_stall_request_o=1, saturates at all-ones; perf_clear_i has priority over increment and zeroes it next cycle.

## Timing
- Reset (rst_i=0 at edge): all entries invalid, flush counter 0, stall_count_o 0; ex_discard_o 0 from the next cycle. Combinational outputs then read 0 with no hazard present.
- Reset mid-flush or mid-stall: state cleared at that edge, no residual discard.
- Stall/fwd outputs: same-cycle combinational from decode inputs and current scoreboard.
- ex_discard_o: rises the cycle after branch_i, high for exactly FLUSH_DEPTH cycles.
- Load-use (FORWARDING=1): exactly 1 stall cycle; the next cycle the load sits in entry 1 and fwd_sel = 2.
- No forwarding: a dependent instruction stalls until the producer retires from entry NB_STAGES-1, i.e. NB_STAGES - k cycles with producer at entry k.
- x0 never matches; destination x0 is never inserted.

## Test plan
- Reset: hold rst_i=0 2 cycles with random inputs -> ex_discard_o=0, stall_count_o=0, no stall on any dec_raddr.
- FORWARDING=1, ALU write x5, next cycle read x5 -> no stall, fwd_sel1_o=1; one cycle later -> 2; after NB_STAGES cycles -> 0.
- FORWARDING=1, load x7 then read x7 via rs2 -> 1 stall cycle, fwd_sel2_o=2 next cycle, stall_count_o=1.
- FORWARDING=0, NB_STAGES=3, write x3 then read x3 -> stall 3 cycles, then release with fwd_sel 0.
- branch_i at cycle t, again at t+1, FLUSH_DEPTH=2 -> ex_discard_o high t+1..t+3, stall masked, no entries inserted.
- CNT_WIDTH=4, stall 20 cycles -> stall_count_o saturates at 15; perf_clear_i -> 0 next cycle.
